ysyx_23060332_mem_arbiter: RTL and testbench
============================================

# ysyx_23060332_mem_arbiter

Two-master arbiter that shares the single physical memory port (DPI-backed pmem read/write block) between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). It sits between IFU/LSU and the memory block. It accepts one request at a time over valid/ready handshakes and drives the memory port for exactly one cycle. It returns registered read data or a write acknowledgement, with an access-fault flag for addresses outside physical memory.

## Interface
- ADDR_LO, 32'h8000_0000, lowest legal physical address (inclusive)
- ADDR_HI, 32'h87FF_FFFF, highest legal physical address (inclusive)

- clk  in  1  system clock, all state on posedge
- rst  in  1  asynchronous, active-high reset
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_req_addr  in  32  IFU fetch address
- ifu_resp_valid  out  1  IFU response available
- ifu_resp_ready  in  1  IFU consumes response
- ifu_resp_rdata  out  32  fetched word
- ifu_resp_err  out  1  access fault
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_req_addr  in  32  LSU address
- lsu_req_wen  in  1  1 = write, 0 = read
- lsu_req_wdata  in  32  store data
- lsu_req_wmask  in  8  byte write mask
- lsu_resp_valid  out  1  LSU response available
- lsu_resp_ready  in  1  LSU consumes response
- lsu_resp_rdata  out  32  load data (0 for writes)
- lsu_resp_err  out  1  access fault
- mem_ren, mem_wen  out  1  memory read/write strobes
- mem_raddr, mem_waddr  out  32  memory addresses
- mem_wdata  out  32  memory write data
- mem_wmask  out  8  memory write mask
- mem_rdata  in  32  combinational read data from memory

## Operation
- FSM states: IDLE, BUSY, RESP. Reset state is IDLE.
- IDLE:
  - Grant logic picks one master from the valid requests.
  - Only the granted master's req_ready is high, combinationally.
  - On handshake, latch master ID, addr, wen, wdata, wmask, and the fault flag (addr < ADDR_LO or addr > ADDR_HI). Go to BUSY.
- BUSY (exactly one cycle):
  - If no fault: drive mem_raddr/mem_waddr = latched addr.
  - Read: mem_ren=1; capture mem_rdata into the response register at the clock edge.
  - Write: mem_wen=1 with latched wdata/wmask; the memory commits on this edge.
  - If fault: both strobes stay 0, rdata register gets 0, err register gets 1.
  - Go to RESP.
- RESP:
  - The owning master's resp_valid=1; rdata and err are held stable.
  - On resp_ready, go to IDLE.
  - The other master's resp_valid stays 0.
- Outside BUSY, all mem_* outputs are 0.
- Both req_ready outputs are 0 in BUSY and RESP.
- Default arbitration is fixed priority: LSU wins when both are valid.
- Write responses carry rdata=0.
- IFU requests are always reads; no wen input exists for IFU.

## Timing
- Request accepted at edge N. Memory is accessed during cycle N+1. resp_valid is high from N+2.
- Minimum occupancy is 3 cycles per transaction; there is no back-to-back acceptance in the RESP→IDLE cycle.
- Reset values: all req_ready, resp_valid, mem_ren and mem_wen = 0; rdata and err = 0; addresses, data and mask = 0; round-robin pointer = IFU.
- Reset asserted mid-operation:
  - The FSM returns to IDLE immediately.
  - Any in-flight write in BUSY is dropped: mem_wen falls asynchronously, so no commit occurs on that edge.
  - A pending response is discarded.
- A request valid that drops before the handshake is ignored; it does not need to be held (no sticky state).
- Boundary addresses: ADDR_LO and ADDR_HI are legal. ADDR_LO-1 and ADDR_HI+1 fault.

## Configuration
- ARB_ROUND_ROBIN_EN
  - Defined: round-robin arbitration. A 1-bit last-grant pointer updates on each accepted handshake. When both masters are valid, grant goes to the master not granted last. The pointer resets to IFU, so the first contention goes to LSU.
  - Undefined: fixed LSU-over-IFU priority; no pointer register exists.

## Structure
- Shared define header:
  - FSM state encoding (ArbIdle, ArbBusy, ArbResp)
  - master IDs (ArbMasterIfu, ArbMasterLsu)
  - default legal address bounds
  - reuse of the existing MemAddrBus/MemDataBus widths
- Sub-module ysyx_23060332_arb_grant holds the grant logic: valids in → one-hot grant out. It contains the round-robin pointer when ARB_ROUND_ROBIN_EN is defined.

## Test plan
- IFU read 0x8000_0000, memory returns 0x0000_0413:
  - ifu_req_ready high at N
  - mem_ren=1, mem_raddr=0x8000_0000 at N+1
  - ifu_resp_valid=1, rdata=0x0000_0413, err=0 at N+2
- LSU write 0x8000_0010, data 0xDEAD_BEEF, mask 0x0F:
  - exactly one cycle of mem_wen with matching waddr, wdata and wmask
  - lsu_resp_valid with rdata=0, err=0
- Both masters valid in the same cycle:
  - without macro: LSU granted, and again on the next contention
  - with ARB_ROUND_ROBIN_EN: LSU, then IFU, then LSU
- LSU read 0x8800_0000 and IFU read 0x7FFF_FFFC:
  - no mem strobe asserted
  - resp err=1, rdata=0
  - 0x87FF_FFFC succeeds with err=0
- Hold resp_ready=0 for 5 cycles in RESP:
  - resp_valid and rdata stay stable
  - neither req_ready rises
  - IDLE is reached one cycle after resp_ready=1
- Assert rst during BUSY of a write:
  - mem_wen=0 at the following edge; no pmem write recorded
  - all outputs at reset values
  - a fresh IFU request after rst deasserts completes normally

Source files
------------

// File: rtl/ysyx_23060332_mem_arbiter_pkg.sv
// Shared definitions for the IFU/LSU memory arbiter: bus widths, FSM states,
// master IDs, legal physical address window and request payload.
package ysyx_23060332_mem_arbiter_pkg;

   localparam int unsigned MemAddrBus = 32;
   localparam int unsigned MemDataBus = 32;
   localparam int unsigned MemMaskBus = 8;

   localparam logic [MemAddrBus-1:0] ARB_ADDR_LO = 32'h8000_0000;
   localparam logic [MemAddrBus-1:0] ARB_ADDR_HI = 32'h87FF_FFFF;

   typedef enum logic [1:0] {
      ArbIdle = 2'd0,
      ArbBusy = 2'd1,
      ArbResp = 2'd2
   } arb_state_e;

   typedef enum logic {
      ArbMasterIfu = 1'b0,
      ArbMasterLsu = 1'b1
   } arb_master_e;

   typedef struct packed {
      logic [MemAddrBus-1:0] addr;
      logic                  wen;
      logic [MemDataBus-1:0] wdata;
      logic [MemMaskBus-1:0] wmask;
   } arb_req_t;

   // Access fault: address outside the physical memory window (bounds inclusive).
   function automatic logic arb_addr_fault(input logic [MemAddrBus-1:0] addr);
      return (addr < ARB_ADDR_LO) || (addr > ARB_ADDR_HI);
   endfunction

endpackage

// File: rtl/ysyx_23060332_arb_grant.sv
// Grant selection between IFU (bit 0) and LSU (bit 1); one-hot out.
// ARB_ROUND_ROBIN_EN selects round-robin with a last-grant pointer, else LSU priority.
module ysyx_23060332_arb_grant
   import ysyx_23060332_mem_arbiter_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
   input  logic       clk,
   input  logic       rst,
   input  logic       i_accept,
`endif
   input  logic       i_ifu_valid,
   input  logic       i_lsu_valid,
   output logic [1:0] o_grant
);

`ifdef ARB_ROUND_ROBIN_EN
   arb_master_e r_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last <= ArbMasterIfu;
      end else if (i_accept) begin
         r_last <= o_grant[1] ? ArbMasterLsu : ArbMasterIfu;
      end
   end

   // On contention, favour the master that was not granted last.
   always_comb begin
      o_grant = 2'b00;
      if (i_ifu_valid && i_lsu_valid) begin
         o_grant = (r_last == ArbMasterLsu) ? 2'b01 : 2'b10;
      end else begin
         o_grant = {i_lsu_valid, i_ifu_valid};
      end
   end
`else
   always_comb begin
      o_grant = {i_lsu_valid, i_ifu_valid && !i_lsu_valid};
   end
`endif

endmodule

// File: rtl/ysyx_23060332_mem_arbiter.sv
// Two-master (IFU/LSU) arbiter onto the single pmem port, one request in flight.
// Build option ARB_ROUND_ROBIN_EN enables round-robin grant instead of LSU priority.
module ysyx_23060332_mem_arbiter
   import ysyx_23060332_mem_arbiter_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ifu_req_valid,
   output logic                  ifu_req_ready,
   input  logic [MemAddrBus-1:0] ifu_req_addr,
   output logic                  ifu_resp_valid,
   input  logic                  ifu_resp_ready,
   output logic [MemDataBus-1:0] ifu_resp_rdata,
   output logic                  ifu_resp_err,
   input  logic                  lsu_req_valid,
   output logic                  lsu_req_ready,
   input  logic [MemAddrBus-1:0] lsu_req_addr,
   input  logic                  lsu_req_wen,
   input  logic [MemDataBus-1:0] lsu_req_wdata,
   input  logic [MemMaskBus-1:0] lsu_req_wmask,
   output logic                  lsu_resp_valid,
   input  logic                  lsu_resp_ready,
   output logic [MemDataBus-1:0] lsu_resp_rdata,
   output logic                  lsu_resp_err,
   output logic                  mem_ren,
   output logic                  mem_wen,
   output logic [MemAddrBus-1:0] mem_raddr,
   output logic [MemAddrBus-1:0] mem_waddr,
   output logic [MemDataBus-1:0] mem_wdata,
   output logic [MemMaskBus-1:0] mem_wmask,
   input  logic [MemDataBus-1:0] mem_rdata
);

   arb_state_e            r_state;
   arb_state_e            w_next;
   arb_master_e           r_id;
   arb_req_t              r_req;
   logic                  r_fault;
   logic [MemDataBus-1:0] r_rdata;
   logic                  r_err;

   logic [1:0]            w_grant;
   logic                  w_idle;
   logic                  w_hs;
   logic                  w_access;
   logic                  w_resp_ready;
   arb_req_t              w_req;

   ysyx_23060332_arb_grant u_grant (
`ifdef ARB_ROUND_ROBIN_EN
      .clk         (clk),
      .rst         (rst),
      .i_accept    (w_hs),
`endif
      .i_ifu_valid (ifu_req_valid),
      .i_lsu_valid (lsu_req_valid),
      .o_grant     (w_grant)
   );

   assign w_idle        = (r_state == ArbIdle);
   assign ifu_req_ready = w_idle && w_grant[0];
   assign lsu_req_ready = w_idle && w_grant[1];
   assign w_hs          = w_idle && (w_grant != 2'b00);
   assign w_resp_ready  = (r_id == ArbMasterLsu) ? lsu_resp_ready : ifu_resp_ready;

   // Payload of the granted master; IFU requests are always reads.
   always_comb begin
      w_req = '0;
      if (w_grant[1]) begin
         w_req.addr  = lsu_req_addr;
         w_req.wen   = lsu_req_wen;
         w_req.wdata = lsu_req_wdata;
         w_req.wmask = lsu_req_wmask;
      end else begin
         w_req.addr  = ifu_req_addr;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ArbIdle: if (w_hs) w_next = ArbBusy;
         ArbBusy: w_next = ArbResp;
         ArbResp: if (w_resp_ready) w_next = ArbIdle;
         default: w_next = ArbIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ArbIdle;
         r_id    <= ArbMasterIfu;
         r_req   <= '0;
         r_fault <= 1'b0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_hs) begin
            r_id    <= w_grant[1] ? ArbMasterLsu : ArbMasterIfu;
            r_req   <= w_req;
            r_fault <= arb_addr_fault(w_req.addr);
         end
         if (r_state == ArbBusy) begin
            r_rdata <= (r_fault || r_req.wen) ? '0 : mem_rdata;
            r_err   <= r_fault;
         end
      end
   end

   // Memory port is live only during BUSY of a legal access; decoding from the
   // state register lets an async reset withdraw a pending write strobe at once.
   assign w_access  = (r_state == ArbBusy) && !r_fault;
   assign mem_ren   = w_access && !r_req.wen;
   assign mem_wen   = w_access && r_req.wen;
   assign mem_raddr = w_access ? r_req.addr : '0;
   assign mem_waddr = w_access ? r_req.addr : '0;
   assign mem_wdata = mem_wen ? r_req.wdata : '0;
   assign mem_wmask = mem_wen ? r_req.wmask : '0;

   assign ifu_resp_valid = (r_state == ArbResp) && (r_id == ArbMasterIfu);
   assign lsu_resp_valid = (r_state == ArbResp) && (r_id == ArbMasterLsu);
   assign ifu_resp_rdata = (r_id == ArbMasterIfu) ? r_rdata : '0;
   assign ifu_resp_err   = (r_id == ArbMasterIfu) && r_err;
   assign lsu_resp_rdata = (r_id == ArbMasterLsu) ? r_rdata : '0;
   assign lsu_resp_err   = (r_id == ArbMasterLsu) && r_err;

endmodule

// File: tb/tb_ysyx_23060332_mem_arbiter.sv
// Self-checking bench for ysyx_23060332_mem_arbiter with a pmem model and a
// transaction-level reference (arbitration order, fault window, memory image).
module tb_ysyx_23060332_mem_arbiter;

   localparam logic [31:0] LO = 32'h8000_0000;
   localparam logic [31:0] HI = 32'h87FF_FFFF;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_req_valid, ifu_req_ready;
   logic [31:0] ifu_req_addr;
   logic        ifu_resp_valid, ifu_resp_ready;
   logic [31:0] ifu_resp_rdata;
   logic        ifu_resp_err;
   logic        lsu_req_valid, lsu_req_ready;
   logic [31:0] lsu_req_addr;
   logic        lsu_req_wen;
   logic [31:0] lsu_req_wdata;
   logic [7:0]  lsu_req_wmask;
   logic        lsu_resp_valid, lsu_resp_ready;
   logic [31:0] lsu_resp_rdata;
   logic        lsu_resp_err;
   logic        mem_ren, mem_wen;
   logic [31:0] mem_raddr, mem_waddr, mem_wdata;
   logic [7:0]  mem_wmask;
   logic [31:0] mem_rdata;

   int checks = 0;
   int errors = 0;
   int wr_count = 0;
   bit last_lsu = 1'b0;

   logic [31:0] pmem    [logic [29:0]];
   logic [31:0] ref_mem [logic [29:0]];

   ysyx_23060332_mem_arbiter dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
      .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
      .ifu_resp_rdata(ifu_resp_rdata), .ifu_resp_err(ifu_resp_err),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
      .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
      .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
      .lsu_resp_rdata(lsu_resp_rdata), .lsu_resp_err(lsu_resp_err),
      .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Background contents of never-written words (nonzero even at address 0).
   function automatic logic [31:0] bg_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
   endfunction

   function automatic logic [31:0] pmem_rd(input logic [31:0] a);
      if (pmem.exists(a[31:2])) return pmem[a[31:2]];
      return bg_word({a[31:2], 2'b00});
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
      return bg_word({a[31:2], 2'b00});
   endfunction

   // Combinational pmem read port; refreshed mid-cycle so writes are visible.
   always @(negedge clk or mem_raddr) mem_rdata = pmem_rd(mem_raddr);

   // pmem write commits at the clock edge while the strobe is high.
   always @(posedge clk) begin
      if (mem_wen) begin
         logic [31:0] w;
         w = pmem_rd(mem_waddr);
         for (int b = 0; b < 4; b++) if (mem_wmask[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
         pmem[mem_waddr[31:2]] = w;
         wr_count++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [7:0] m);
      logic [31:0] w;
      w = ref_rd(a);
      for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
      ref_mem[a[31:2]] = w;
   endtask

   task automatic preload(input logic [31:0] a, input logic [31:0] d);
      pmem[a[31:2]]    = d;
      ref_mem[a[31:2]] = d;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, ".ifu_req_ready"},  32'(ifu_req_ready), 32'd0);
      chk({tag, ".lsu_req_ready"},  32'(lsu_req_ready), 32'd0);
      chk({tag, ".ifu_resp_valid"}, 32'(ifu_resp_valid), 32'd0);
      chk({tag, ".lsu_resp_valid"}, 32'(lsu_resp_valid), 32'd0);
      chk({tag, ".ifu_resp_rdata"}, ifu_resp_rdata, 32'd0);
      chk({tag, ".lsu_resp_rdata"}, lsu_resp_rdata, 32'd0);
      chk({tag, ".resp_err"},       32'({ifu_resp_err, lsu_resp_err}), 32'd0);
      chk({tag, ".mem_strobes"},    32'({mem_ren, mem_wen}), 32'd0);
      chk({tag, ".mem_raddr"},      mem_raddr, 32'd0);
      chk({tag, ".mem_waddr"},      mem_waddr, 32'd0);
      chk({tag, ".mem_wdata"},      mem_wdata, 32'd0);
      chk({tag, ".mem_wmask"},      32'(mem_wmask), 32'd0);
   endtask

   // One transaction; the model decides the winner when both masters are valid.
   task automatic run(input string tag, input bit iv, input bit lv,
                      input logic [31:0] ia, input logic [31:0] la, input bit wen,
                      input logic [31:0] wd, input logic [7:0] wm, input int hold);
      bit g_lsu, w, flt;
      logic [31:0] a, er;
      int wc0;
`ifdef ARB_ROUND_ROBIN_EN
      g_lsu = lv && (!iv || !last_lsu);
`else
      g_lsu = lv;
`endif
      last_lsu = g_lsu;
      a   = g_lsu ? la : ia;
      w   = g_lsu && wen;
      flt = (a < LO) || (a > HI);

      @(negedge clk);
      ifu_req_valid = iv; ifu_req_addr = ia;
      lsu_req_valid = lv; lsu_req_addr = la; lsu_req_wen = wen;
      lsu_req_wdata = wd; lsu_req_wmask = wm;
      #1;
      chk({tag, ".ifu_req_ready"}, 32'(ifu_req_ready), 32'(!g_lsu));
      chk({tag, ".lsu_req_ready"}, 32'(lsu_req_ready), 32'(g_lsu));
      @(posedge clk); #1;
      ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;

      @(negedge clk);
      chk({tag, ".busy_ren"}, 32'(mem_ren), 32'(!flt && !w));
      chk({tag, ".busy_wen"}, 32'(mem_wen), 32'(!flt && w));
      if (!flt && w) begin
         chk({tag, ".waddr"}, mem_waddr, a);
         chk({tag, ".wdata"}, mem_wdata, wd);
         chk({tag, ".wmask"}, 32'(mem_wmask), 32'(wm));
      end else if (!flt) begin
         chk({tag, ".raddr"}, mem_raddr, a);
      end
      er = (flt || w) ? 32'd0 : ref_rd(a);
      if (!flt && w) ref_write(a, wd, wm);
      wc0 = wr_count;

      @(negedge clk);
      chk({tag, ".writes"}, 32'(wr_count), 32'(wc0 + ((!flt && w) ? 1 : 0)));
      chk({tag, ".resp_strobes_off"}, 32'({mem_ren, mem_wen}), 32'd0);
      for (int c = 0; c <= hold; c++) begin
         if (c > 0) @(negedge clk);
         chk({tag, ".ifu_resp_valid"}, 32'(ifu_resp_valid), 32'(!g_lsu));
         chk({tag, ".lsu_resp_valid"}, 32'(lsu_resp_valid), 32'(g_lsu));
         chk({tag, ".rdata"}, g_lsu ? lsu_resp_rdata : ifu_resp_rdata, er);
         chk({tag, ".err"}, 32'(g_lsu ? lsu_resp_err : ifu_resp_err), 32'(flt));
         if (c > 0) chk({tag, ".hold_req_ready"}, 32'({ifu_req_ready, lsu_req_ready}), 32'd0);
         if (c < hold) begin
            ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
         end
      end
      ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
      if (g_lsu) lsu_resp_ready = 1'b1; else ifu_resp_ready = 1'b1;
      @(posedge clk); #1;
      ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
      chk({tag, ".idle_resp_valid"}, 32'({ifu_resp_valid, lsu_resp_valid}), 32'd0);
   endtask

   function automatic logic [31:0] rand_addr();
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel == 0) return LO - 32'(1 + $urandom_range(0, 15));
      if (sel == 1) return HI + 32'(1 + $urandom_range(0, 15));
      return LO + 32'($urandom_range(0, 63) << 2);
   endfunction

   initial begin
      int wc0;
      rst = 1'b1;
      ifu_req_valid = 0; ifu_req_addr = '0; ifu_resp_ready = 0;
      lsu_req_valid = 0; lsu_req_addr = '0; lsu_req_wen = 0;
      lsu_req_wdata = '0; lsu_req_wmask = '0; lsu_resp_ready = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      preload(32'h8000_0000, 32'h0000_0413);
      run("ifu_read", 1, 0, 32'h8000_0000, 32'h0, 0, 32'h0, 8'h0, 0);
      run("contend1", 1, 1, 32'h8000_0100, 32'h8000_0200, 0, 32'h0, 8'h0, 0);
      run("contend2", 1, 1, 32'h8000_0104, 32'h8000_0204, 0, 32'h0, 8'h0, 0);
      run("contend3", 1, 1, 32'h8000_0108, 32'h8000_0208, 0, 32'h0, 8'h0, 0);
      run("lsu_write", 0, 1, 32'h0, 32'h8000_0010, 1, 32'hDEAD_BEEF, 8'h0F, 0);
      run("lsu_readback", 0, 1, 32'h0, 32'h8000_0010, 0, 32'h0, 8'h0, 0);
      run("lsu_fault_hi", 0, 1, 32'h0, 32'h8800_0000, 0, 32'h0, 8'h0, 0);
      run("ifu_fault_lo", 1, 0, 32'h7FFF_FFFC, 32'h0, 0, 32'h0, 8'h0, 0);
      run("lsu_near_hi", 0, 1, 32'h0, 32'h87FF_FFFC, 0, 32'h0, 8'h0, 0);
      run("lsu_at_lo", 0, 1, 32'h0, LO, 0, 32'h0, 8'h0, 0);
      run("ifu_at_hi", 1, 0, HI, 32'h0, 0, 32'h0, 8'h0, 0);
      run("ifu_lo_m1", 1, 0, LO - 32'd1, 32'h0, 0, 32'h0, 8'h0, 0);
      run("lsu_hi_p1", 0, 1, 32'h0, HI + 32'd1, 0, 32'h0, 8'h0, 0);
      run("lsu_fault_wr", 0, 1, 32'h0, 32'h9000_0000, 1, 32'h1111_2222, 8'hFF, 0);
      run("hold5", 1, 0, 32'h8000_0010, 32'h0, 0, 32'h0, 8'h0, 5);

      // Reset during BUSY of a write: strobe withdrawn, nothing committed.
      @(negedge clk);
      lsu_req_valid = 1; lsu_req_addr = 32'h8000_0020; lsu_req_wen = 1;
      lsu_req_wdata = 32'hCAFE_F00D; lsu_req_wmask = 8'hFF;
      @(posedge clk); #1;
      lsu_req_valid = 0;
      @(negedge clk);
      chk("rst_busy.wen_before", 32'(mem_wen), 32'd1);
      wc0 = wr_count;
      rst = 1'b1;
      #1;
      check_reset_outputs("rst_busy");
      @(posedge clk); #1;
      chk("rst_busy.no_commit", 32'(wr_count), 32'(wc0));
      check_reset_outputs("rst_held");
      @(negedge clk);
      rst = 1'b0;
      last_lsu = 1'b0;
      run("after_rst", 1, 0, 32'h8000_0020, 32'h0, 0, 32'h0, 8'h0, 0);

      for (int i = 0; i < 40; i++) begin
         int kind;
         kind = int'($urandom_range(0, 2));
         run($sformatf("rand%0d", i), kind != 1, kind != 0, rand_addr(), rand_addr(),
             1'($urandom_range(0, 1)), $urandom, 8'($urandom_range(0, 255)),
             int'($urandom_range(0, 3)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
